// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: channel state encoding
// and width helpers used to size the per-channel counters.
package btn_pkg;

  typedef enum logic [1:0] {
    REL      = 2'd0,
    HOLD_DLY = 2'd1,
    HOLD_REP = 2'd2
  } chan_state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: synchroniser, stability-counter debounce, and a
// press / hold-delay / auto-repeat FSM producing registered pulses.
module btn_chan
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 550000,
  parameter int REP_DELAY   = 50000000,
  parameter int REP_PERIOD  = 10000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        btn_i,
  input  logic        rep_en_i,
  output logic        deb_o,
  output logic        pulse_o,
  output logic        rel_pulse_o,
  output chan_state_e state_o
);

  localparam int DW = clog2(DEB_CYCLES + 1);
  localparam int RW = clog2(max2(REP_DELAY, REP_PERIOD) + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] DLY_SAT  = RW'(REP_DELAY);
  localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   deb_q, deb_d;
  logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
  logic                   press_evt, rel_evt;
  chan_state_e            state_q, state_d;
  logic [RW-1:0]          rep_cnt_q, rep_cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   rel_q, rel_d;

  assign s = sync_q[SYNC_STAGES-1];

  // The counter only runs while the synchronised level disagrees with deb_q.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    press_evt = 1'b0;
    rel_evt   = 1'b0;
    if (s != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d     = s;
        press_evt = s;
        rel_evt   = ~s;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      state_q   <= REL;
      rep_cnt_q <= '0;
      pulse_q   <= 1'b0;
      rel_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      pulse_q   <= pulse_d;
      rel_q     <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REL:      if (press_evt) state_d = HOLD_DLY;
      HOLD_DLY: begin
        if (rel_evt) state_d = REL;
        else if (rep_cnt_q >= DLY_LAST && rep_en_i) state_d = HOLD_REP;
      end
      HOLD_REP: begin
        if (rel_evt) state_d = REL;
        else if (!rep_en_i) state_d = HOLD_DLY;
      end
      default:  state_d = REL;
    endcase
  end

  // A release suppresses any repeat that would coincide with it.
  always_comb begin
    pulse_d   = 1'b0;
    rel_d     = rel_evt;
    rep_cnt_d = rep_cnt_q;
    case (state_q)
      REL: begin
        rep_cnt_d = '0;
        pulse_d   = press_evt;
      end
      HOLD_DLY: begin
        if (!rel_evt) begin
          if (rep_cnt_q >= DLY_LAST) begin
            if (rep_en_i) begin
              pulse_d   = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = DLY_SAT;
            end
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end
      HOLD_REP: begin
        if (!rel_evt) begin
          if (!rep_en_i) begin
            rep_cnt_d = DLY_SAT;
          end else if (rep_cnt_q >= PER_LAST) begin
            pulse_d   = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end
      default: rep_cnt_d = '0;
    endcase
  end

  assign deb_o       = deb_q;
  assign pulse_o     = pulse_q;
  assign rel_pulse_o = rel_q;
  assign state_o     = state_q;

endmodule

// File: rtl/btn_pulse_ctlr.sv
// N-channel push-button front end; one independent btn_chan per button.
// dbg_state carries each channel's FSM state, two bits per channel.
module btn_pulse_ctlr
  import btn_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 550000,
  parameter int REP_DELAY   = 50000000,
  parameter int REP_PERIOD  = 10000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_BTN-1:0]   btn_in,
  input  logic [N_BTN-1:0]   rep_en,
  output logic [N_BTN-1:0]   deb_out,
  output logic [N_BTN-1:0]   pulse,
  output logic [N_BTN-1:0]   rel_pulse,
  output logic [2*N_BTN-1:0] dbg_state
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    chan_state_e st;

    btn_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES),
      .REP_DELAY   (REP_DELAY),
      .REP_PERIOD  (REP_PERIOD)
    ) u_chan (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .btn_i       (btn_in[i]),
      .rep_en_i    (rep_en[i]),
      .deb_o       (deb_out[i]),
      .pulse_o     (pulse[i]),
      .rel_pulse_o (rel_pulse[i]),
      .state_o     (st)
    );

    assign dbg_state[2*i +: 2] = st;
  end

endmodule

// File: tb/tb_btn_pulse_ctlr.sv
// Directed bench for btn_pulse_ctlr with short debounce and repeat timings.
module tb_btn_pulse_ctlr;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic [N-1:0] rep_en;
  logic [N-1:0] deb_out;
  logic [N-1:0] pulse;
  logic [N-1:0] rel_pulse;
  logic [2*N-1:0] dbg_state;

  btn_pulse_ctlr #(
    .N_BTN       (N),
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4),
    .REP_DELAY   (10),
    .REP_PERIOD  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .rep_en    (rep_en),
    .deb_out   (deb_out),
    .pulse     (pulse),
    .rel_pulse (rel_pulse),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int pcnt[N];
  int rcnt[N];
  bit deb1_seen;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: sample outputs 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (pulse[i] === 1'b1) pcnt[i]++;
      if (rel_pulse[i] === 1'b1) rcnt[i]++;
    end
    if (deb_out[1] === 1'b1) deb1_seen = 1'b1;
    if (pulse[2] === 1'b1) obs_q.push_back(32'(cyc));
  endtask

  task automatic clr_counts();
    for (int i = 0; i < N; i++) begin
      pcnt[i] = 0;
      rcnt[i] = 0;
    end
  endtask

  task automatic chk_offsets(input string tag, input int base);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      chk({tag, "_offset"}, obs_q[k] - 32'(base), exp_q[k]);
  endtask

  int base;

  initial begin
    rst_n  = 1'b0;
    btn_in = '0;
    rep_en = '0;
    deb1_seen = 1'b0;
    clr_counts();
    repeat (3) step();
    chk("reset_deb", 32'(deb_out), 0);
    chk("reset_pulse", 32'(pulse), 0);
    chk("reset_rel", 32'(rel_pulse), 0);
    chk("reset_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Clean press on ch0, no repeat.
    clr_counts();
    btn_in[0] = 1'b1;
    repeat (5) step();
    chk("press0_deb_early", 32'(deb_out[0]), 0);
    step();
    chk("press0_deb", 32'(deb_out[0]), 1);
    chk("press0_pulse", 32'(pulse[0]), 1);
    step();
    chk("press0_pulse_once", 32'(pulse[0]), 0);
    chk("press0_state", 32'(dbg_state[1:0]), 1);
    repeat (28) step();
    chk("hold0_pulses", 32'(pcnt[0]), 1);
    btn_in[0] = 1'b0;
    repeat (5) step();
    chk("rel0_deb_early", 32'(deb_out[0]), 1);
    chk("rel0_rel_early", 32'(rel_pulse[0]), 0);
    step();
    chk("rel0_deb", 32'(deb_out[0]), 0);
    chk("rel0_rel", 32'(rel_pulse[0]), 1);
    step();
    chk("rel0_rel_once", 32'(rel_pulse[0]), 0);
    chk("rel0_count", 32'(rcnt[0]), 1);

    // Bounce on ch1: 3 high, 1 low, 3 high, then low.
    clr_counts();
    btn_in[1] = 1'b1; repeat (3) step();
    btn_in[1] = 1'b0; step();
    btn_in[1] = 1'b1; repeat (3) step();
    btn_in[1] = 1'b0; repeat (8) step();
    chk("bounce1_deb", 32'(deb1_seen), 0);
    chk("bounce1_pulses", 32'(pcnt[1]), 0);
    chk("bounce1_rels", 32'(rcnt[1]), 0);

    // Auto-repeat on ch2; release lands on the offset-25 repeat slot.
    clr_counts();
    obs_q.delete();
    exp_q = '{32'd0, 32'd10, 32'd13, 32'd16, 32'd19, 32'd22};
    rep_en[2] = 1'b1;
    btn_in[2] = 1'b1;
    repeat (6) step();
    chk("rep2_press", 32'(pulse[2]), 1);
    base = cyc;
    repeat (19) step();
    btn_in[2] = 1'b0;
    repeat (6) step();
    chk("rep2_rel", 32'(rel_pulse[2]), 1);
    chk("rep2_rel_wins", 32'(pulse[2]), 0);
    chk("rep2_rel_deb", 32'(deb_out[2]), 0);
    repeat (10) step();
    chk("rep2_rel_count", 32'(rcnt[2]), 1);
    chk_offsets("rep2", base);

    // rep_en dropped at offset 14, raised at offset 20; release at 26.
    clr_counts();
    obs_q.delete();
    exp_q = '{32'd0, 32'd10, 32'd13, 32'd20, 32'd23};
    btn_in[2] = 1'b1;
    repeat (6) step();
    base = cyc;
    repeat (13) step();
    rep_en[2] = 1'b0;
    step();
    chk("gap2_state", 32'(dbg_state[5:4]), 1);
    repeat (5) step();
    rep_en[2] = 1'b1;
    step();
    btn_in[2] = 1'b0;
    repeat (6) step();
    chk("gap2_rel", 32'(rel_pulse[2]), 1);
    chk("gap2_rel_wins", 32'(pulse[2]), 0);
    repeat (6) step();
    chk_offsets("gap2", base);
    rep_en[2] = 1'b0;

    // All four buttons in the same cycle.
    clr_counts();
    btn_in = 4'hF;
    repeat (5) step();
    chk("all_pulse_early", 32'(pulse), 0);
    step();
    chk("all_pulse", 32'(pulse), 32'hF);
    step();
    chk("all_pulse_after", 32'(pulse), 0);
    chk("all_deb", 32'(deb_out), 32'hF);
    btn_in = 4'h0;
    repeat (6) step();
    chk("all_rel", 32'(rel_pulse), 32'hF);
    chk("all_rel_deb", 32'(deb_out), 0);
    step();

    // Reset in the middle of a repeat hold on ch3, button kept held.
    rep_en[3] = 1'b1;
    btn_in[3] = 1'b1;
    repeat (6) step();
    chk("rst3_press", 32'(pulse[3]), 1);
    repeat (5) step();
    chk("rst3_hold_state", 32'(dbg_state[7:6]), 1);
    chk("rst3_hold_deb", 32'(deb_out[3]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst3_deb", 32'(deb_out), 0);
    chk("rst3_pulse", 32'(pulse), 0);
    chk("rst3_state", 32'(dbg_state), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst3_repress_early", 32'(pulse[3]), 0);
    step();
    chk("rst3_repress", 32'(pulse[3]), 1);
    chk("rst3_repress_deb", 32'(deb_out[3]), 1);
    btn_in[3] = 1'b0;
    rep_en[3] = 1'b0;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
